// File: rtl/alu_decode_stage.sv
// RV32I decode stage: instruction word to registered ALU control bundle, 1-cycle latency.
// Two-entry main/skid storage keeps full throughput under backpressure; in_ready is a pure flop output.
module alu_decode_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [2:0]  out_func3,
  output logic [6:0]  out_func7,
  output logic        out_add_force,
  output logic        out_is_imm,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_use_rs2,
  output logic        out_use_pc,
  output logic        out_reg_write,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        add_force;
    logic        is_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        use_rs2;
    logic        use_pc;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  bundle_t     dec;
  bundle_t     main_q, main_d, skid_q, skid_d;
  logic        main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic        accept;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.func3 = f3;
    dec.func7 = f7;
    dec.rs1   = in_instr[19:15];
    dec.rs2   = in_instr[24:20];
    dec.rd    = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.use_rs2   = 1'b1;
        dec.reg_write = 1'b1;
        dec.illegal   = !((f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec.is_imm    = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        // Shift-immediates reuse the func7 field, so it must carry a valid shift kind.
        dec.illegal   = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                        ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      OPC_LOAD: begin
        dec.add_force = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.add_force = 1'b1;
        dec.use_rs2   = 1'b1;
        dec.imm       = imm_s;
      end
      OPC_BRANCH: begin
        dec.use_rs2 = 1'b1;
        dec.imm     = imm_b;
      end
      OPC_LUI: begin
        dec.add_force = 1'b1;
        dec.rs1       = 5'd0;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.add_force = 1'b1;
        dec.use_pc    = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) dec.reg_write = 1'b0;
  end

  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      // Skid full implies in_ready=0, so no new bundle competes for main here.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid     = main_vld_q;
  assign out_pc        = main_q.pc;
  assign out_func3     = main_q.func3;
  assign out_func7     = main_q.func7;
  assign out_add_force = main_q.add_force;
  assign out_is_imm    = main_q.is_imm;
  assign out_imm       = main_q.imm;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_use_rs2   = main_q.use_rs2;
  assign out_use_pc    = main_q.use_pc;
  assign out_reg_write = main_q.reg_write;
  assign out_illegal   = main_q.illegal;

endmodule
